difftest_step_scheduler: RTL and testbench
==========================================

Name: difftest_step_scheduler

Overview:
- Multi-core commit-step scheduler between the DUT cores' per-cycle difftest step outputs and the single software checker channel.
- Accumulates each core's committed-instruction steps and issues one batched check request at a time, round-robin across cores, over a valid/ready channel.
- Consumes checker results, folds in core exit codes, and runs the stuck watchdog.
- Drives the overall simulation state and the perf-dump pulse.

Parameters:
- NUM_CORES, 2, number of cores sharing the checker channel (1..8)
- STEP_W, 8, per-core per-cycle step width (matches CONFIG_DIFFTEST_STEPWIDTH)
- ACC_W, 16, per-core step accumulator width; also width of req_nstep
- STUCK_W, 32, stuck watchdog counter width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- core_step  in  NUM_CORES*STEP_W  per-core steps committed this cycle; core i in bits [i*STEP_W +: STEP_W]
- core_exit_valid  in  NUM_CORES  single-cycle exit report per core
- core_exit_good  in  NUM_CORES  qualifies core_exit_valid; 1 = normal exit, 0 = abort
- stuck_limit  in  STUCK_W  idle-cycle limit; 0 disables the watchdog
- req_valid  out  1  check request valid
- req_ready  in  1  checker accepts request
- req_core  out  $clog2(NUM_CORES) (min 1)  core index of the request
- req_nstep  out  ACC_W  batched step count; never 0 while req_valid
- rsp_valid  in  1  checker result valid
- rsp_result  in  8  0 = ok, 1 = done, 2 = fail; other values are treated as fail
- sim_state  out  2  0 RUN, 1 DONE, 2 FAIL, 3 STUCK
- perf_dump  out  1  one-cycle pulse on entry to any terminal state
- acc_overflow  out  1  sticky; set when any accumulator saturates

Behaviour:
- Reset (reset==0, async): FSM=INIT; all accumulators, exit masks, watchdog and RR pointer cleared.
- Reset values: req_valid=0, req_core=0, req_nstep=0, sim_state=RUN, perf_dump=0, acc_overflow=0.
- Reset asserted mid-handshake drops req_valid immediately; the pending request is lost.
- FSM states: INIT -> ARB (one cycle after reset release).
- ARB: grant the first core with acc!=0, searching from rr_ptr upward with wrap.
  - On grant: latch req_core/req_nstep = acc[g]; acc[g] <= core_step[g] in the same edge, so no step is lost; rr_ptr <= g+1 mod NUM_CORES; go to REQ.
  - No eligible core: stay in ARB.
- REQ: req_valid=1; req_core and req_nstep held stable. Go to WAIT on req_valid&&req_ready.
- WAIT: on rsp_valid:
  - result 0 -> ARB
  - result 1 -> DONE
  - result 2 or illegal -> FAIL
- rsp_valid in any state other than WAIT is ignored.
- DONE, FAIL, STUCK are terminal until reset. req_valid=0 in these states; accumulation stops.
- Request latency: 1 cycle from acc!=0 in ARB to req_valid=1.
- Accumulation, every RUN cycle for each core not being granted: acc += core_step, saturating at 2^ACC_W-1; saturation sets acc_overflow.
- Exit handling:
  - core_exit_valid&&!core_exit_good -> FAIL next cycle, from any non-terminal state.
  - good exits set bits in a sticky exit mask.
  - DONE when the exit mask is all ones, all acc==0, and FSM is in ARB.
- Watchdog: counter clears on any nonzero core_step and otherwise increments, saturating. STUCK when stuck_limit!=0 && counter>=stuck_limit.
- Simultaneous terminal causes in one cycle: FAIL > DONE > STUCK.
- perf_dump is high for exactly the first cycle sim_state is terminal.

Decomposition:
- Package difftest_sched_pkg holds:
  - sim_state enum (RUN/DONE/FAIL/STUCK)
  - rsp code constants RSP_OK=1'h0... as 8-bit: OK=0, DONE=1, FAIL=2
  - FSM state enum (INIT/ARB/REQ/WAIT/TERM)
- One sub-module, difftest_rr_pick: combinational round-robin first-one search over an eligibility vector from rr_ptr, returning grant index and a found flag.

Test Plan:
- Single step, NUM_CORES=2: core_step[0]=3 for one cycle, req_ready=1, rsp 0 -> req_core=0, req_nstep=3 one cycle later; back to ARB; no further request.
- Round-robin: both cores step 1 every cycle, checker always ready, rsp ok after 2 cycles -> requests alternate core 0,1,0,1; each req_nstep equals that core's steps since its last grant; total steps conserved.
- Backpressure: req_ready=0 for 10 cycles while core 0 keeps stepping 2/cycle -> req_nstep stays constant; post-accept acc contains the 20 new steps.
- Saturation: ACC_W=4, core 0 steps 8/cycle with req_ready=0 -> acc caps at 15 and acc_overflow goes to 1 and stays 1.
- Terminal priority: in one cycle, rsp_result=1 in WAIT and core 1 bad exit -> sim_state=FAIL; perf_dump=1 for exactly one cycle.
- Watchdog: stuck_limit=5, no steps -> STUCK at the 5th idle cycle. Repeat with stuck_limit=0 -> RUN indefinitely. Async reset mid-REQ -> req_valid=0 the same cycle.

Source files
------------

// File: rtl/difftest_sched_pkg.sv
// Shared types and constants for the difftest step scheduler.
// Holds the simulation verdict encoding, checker response codes and the scheduler FSM states.
package difftest_sched_pkg;

    typedef enum logic [1:0] {
        SIM_RUN   = 2'd0,
        SIM_DONE  = 2'd1,
        SIM_FAIL  = 2'd2,
        SIM_STUCK = 2'd3
    } sim_state_e;

    localparam logic [7:0] RSP_OK   = 8'd0;
    localparam logic [7:0] RSP_DONE = 8'd1;
    localparam logic [7:0] RSP_FAIL = 8'd2;

    typedef enum logic [2:0] {
        FSM_INIT,
        FSM_ARB,
        FSM_REQ,
        FSM_WAIT,
        FSM_TERM
    } fsm_e;

    // Index width for a core count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/difftest_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above i_ptr, wrapping.
// Rotates the eligibility vector so the search always starts at bit 0.
module difftest_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_found
);

    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_off;
    logic [IDX_W:0] w_sum;

    assign w_rot = N'({i_elig, i_elig} >> i_ptr);

    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_off   = (IDX_W+1)'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (IDX_W+1)'(N)) begin
            w_sum = w_sum - (IDX_W+1)'(N);
        end
        o_grant = IDX_W'(w_sum);
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches per-core committed steps into round-robin check requests for a single checker
// channel, folds in checker verdicts, core exits and a stuck watchdog into the sim state.
module difftest_step_scheduler
    import difftest_sched_pkg::*;
#(
    parameter  int NUM_CORES = 2,
    parameter  int STEP_W    = 8,
    parameter  int ACC_W     = 16,
    parameter  int STUCK_W   = 32,
    localparam int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES*STEP_W-1:0] core_step,
    input  logic [NUM_CORES-1:0]        core_exit_valid,
    input  logic [NUM_CORES-1:0]        core_exit_good,
    input  logic [STUCK_W-1:0]          stuck_limit,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [IDX_W-1:0]            req_core,
    output logic [ACC_W-1:0]            req_nstep,
    input  logic                        rsp_valid,
    input  logic [7:0]                  rsp_result,
    output logic [1:0]                  sim_state,
    output logic                        perf_dump,
    output logic                        acc_overflow
);

    // Returns {saturated, value}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [STEP_W-1:0] s);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(s);
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    logic [ACC_W-1:0]   r_acc [NUM_CORES];
    logic [NUM_CORES-1:0] r_exit_mask;
    logic [STUCK_W-1:0] r_wdog;
    logic [IDX_W-1:0]   r_rr_ptr;
    fsm_e               r_fsm;
    sim_state_e         r_sim_state;
    logic               r_req_valid;
    logic [IDX_W-1:0]   r_req_core;
    logic [ACC_W-1:0]   r_req_nstep;
    logic               r_perf_dump;
    logic               r_acc_ovf;

    logic [ACC_W-1:0]     w_acc_nxt [NUM_CORES];
    logic [NUM_CORES-1:0] w_sat;
    logic [NUM_CORES-1:0] w_elig;
    logic [NUM_CORES-1:0] w_gmask;
    logic [IDX_W-1:0]     w_grant;
    logic                 w_found;
    logic                 w_running;
    logic                 w_rsp_take;
    logic                 w_fail;
    logic                 w_done;
    logic                 w_stuck;
    logic                 w_term;
    logic                 w_grant_en;
    logic [IDX_W-1:0]     w_rr_next;

    difftest_rr_pick #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_elig[i] = (r_acc[i] != '0);
            {w_sat[i], w_acc_nxt[i]} = sat_add(r_acc[i], core_step[i*STEP_W +: STEP_W]);
        end
    end

    // Terminal causes are evaluated combinationally and resolved FAIL > DONE > STUCK.
    assign w_running  = (r_fsm != FSM_TERM);
    assign w_rsp_take = (r_fsm == FSM_WAIT) && rsp_valid;
    assign w_fail     = (|(core_exit_valid & ~core_exit_good))
                      || (w_rsp_take && (rsp_result >= RSP_FAIL));
    assign w_done     = (w_rsp_take && (rsp_result == RSP_DONE))
                      || ((r_fsm == FSM_ARB) && (&r_exit_mask) && !(|w_elig));
    assign w_stuck    = (stuck_limit != '0) && (r_wdog >= stuck_limit);
    assign w_term     = w_running && (w_fail || w_done || w_stuck);
    assign w_grant_en = (r_fsm == FSM_ARB) && w_found && !w_term;
    assign w_rr_next  = (w_grant == IDX_W'(NUM_CORES - 1)) ? '0 : w_grant + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_gmask[i] = w_grant_en && (w_grant == IDX_W'(i));
        end
    end

    // Accumulators, exit mask and watchdog freeze once the run is terminal.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_acc[i] <= '0;
            end
            r_exit_mask <= '0;
            r_wdog      <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (w_running) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_gmask[i]) begin
                    r_acc[i] <= ACC_W'(core_step[i*STEP_W +: STEP_W]);
                end else begin
                    r_acc[i] <= w_acc_nxt[i];
                end
            end
            r_acc_ovf   <= r_acc_ovf | (|(w_sat & ~w_gmask));
            r_exit_mask <= r_exit_mask | (core_exit_valid & core_exit_good);
            if (|core_step) begin
                r_wdog <= '0;
            end else if (r_wdog != '1) begin
                r_wdog <= r_wdog + STUCK_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm       <= FSM_INIT;
            r_sim_state <= SIM_RUN;
            r_rr_ptr    <= '0;
            r_req_valid <= 1'b0;
            r_req_core  <= '0;
            r_req_nstep <= '0;
            r_perf_dump <= 1'b0;
        end else begin
            r_perf_dump <= 1'b0;
            if (w_term) begin
                r_fsm       <= FSM_TERM;
                r_req_valid <= 1'b0;
                r_perf_dump <= 1'b1;
                if (w_fail) begin
                    r_sim_state <= SIM_FAIL;
                end else if (w_done) begin
                    r_sim_state <= SIM_DONE;
                end else begin
                    r_sim_state <= SIM_STUCK;
                end
            end else begin
                case (r_fsm)
                    FSM_INIT: r_fsm <= FSM_ARB;
                    FSM_ARB: begin
                        if (w_grant_en) begin
                            r_req_core  <= w_grant;
                            r_req_nstep <= r_acc[w_grant];
                            r_rr_ptr    <= w_rr_next;
                            r_req_valid <= 1'b1;
                            r_fsm       <= FSM_REQ;
                        end
                    end
                    FSM_REQ: begin
                        if (r_req_valid && req_ready) begin
                            r_req_valid <= 1'b0;
                            r_fsm       <= FSM_WAIT;
                        end
                    end
                    // Only an OK verdict reaches here; DONE/FAIL are taken as terminal above.
                    FSM_WAIT: begin
                        if (rsp_valid) begin
                            r_fsm <= FSM_ARB;
                        end
                    end
                    default: r_fsm <= r_fsm;
                endcase
            end
        end
    end

    assign req_valid    = r_req_valid;
    assign req_core     = r_req_core;
    assign req_nstep    = r_req_nstep;
    assign sim_state    = r_sim_state;
    assign perf_dump    = r_perf_dump;
    assign acc_overflow = r_acc_ovf;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Scoreboard bench for difftest_step_scheduler: directed scenarios push expected requests,
// a monitor pops and compares on every accepted request.
module tb_difftest_step_scheduler;

    localparam int NC = 2;
    localparam int SW = 8;
    localparam int AW = 16;
    localparam int KW = 32;

    typedef struct {
        int core;
        int nstep;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC*SW-1:0] core_step;
    logic [NC-1:0]   exit_v;
    logic [NC-1:0]   exit_g;
    logic [KW-1:0]   stuck_limit;
    logic            req_valid;
    logic            req_ready;
    logic [0:0]      req_core;
    logic [AW-1:0]   req_nstep;
    logic            rsp_valid;
    logic [7:0]      rsp_result;
    logic [1:0]      sim_state;
    logic            perf_dump;
    logic            acc_overflow;

    logic            auto_rsp;
    logic            a_valid;
    logic            m_valid;
    logic [7:0]      m_code;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_accept = 0;

    always #5 clk = ~clk;

    assign rsp_valid  = auto_rsp ? a_valid : m_valid;
    assign rsp_result = auto_rsp ? 8'd0 : m_code;

    difftest_step_scheduler #(
        .NUM_CORES (NC),
        .STEP_W    (SW),
        .ACC_W     (AW),
        .STUCK_W   (KW)
    ) dut (
        .clock           (clk),
        .reset           (reset),
        .core_step       (core_step),
        .core_exit_valid (exit_v),
        .core_exit_good  (exit_g),
        .stuck_limit     (stuck_limit),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_core        (req_core),
        .req_nstep       (req_nstep),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .sim_state       (sim_state),
        .perf_dump       (perf_dump),
        .acc_overflow    (acc_overflow)
    );

    // Monitor: compares every accepted request against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && req_valid === 1'b1) begin
                n_tests++;
                if (req_nstep == '0) begin
                    n_fail++;
                    $display("FAIL req_nstep_nonzero: got %0d while req_valid, required nonzero", req_nstep);
                end
                if (req_ready === 1'b1) begin
                    n_accept++;
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_req: got core %0d nstep %0d, required no request",
                                 req_core, req_nstep);
                    end else begin
                        e = sb.pop_front();
                        if (int'(req_core) != e.core || int'(req_nstep) != e.nstep) begin
                            n_fail++;
                            $display("FAIL sb_req: got core %0d nstep %0d, required core %0d nstep %0d",
                                     req_core, req_nstep, e.core, e.nstep);
                        end
                    end
                end
            end
        end
    end

    // Auto checker: answers OK two cycles after each accepted request.
    initial begin
        int seen;
        int pend;
        seen    = 0;
        pend    = 0;
        a_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_rsp === 1'b1 && reset === 1'b1) begin
                if (n_accept != seen) begin
                    seen = n_accept;
                    pend = 2;
                end
                if (pend > 0) begin
                    pend--;
                    a_valid = (pend == 0);
                end else begin
                    a_valid = 1'b0;
                end
            end else begin
                seen    = n_accept;
                pend    = 0;
                a_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int n);
        exp_t e;
        e.core  = c;
        e.nstep = n;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        core_step   = '0;
        exit_v      = '0;
        exit_g      = '0;
        stuck_limit = '0;
        req_ready   = 1'b1;
        auto_rsp    = 1'b1;
        m_valid     = 1'b0;
        m_code      = 8'd0;
        repeat (2) tick();
        check("rst_req_valid", req_valid, 0);
        check("rst_req_core", req_core, 0);
        check("rst_req_nstep", req_nstep, 0);
        check("rst_sim_state", sim_state, 0);
        check("rst_perf_dump", perf_dump, 0);
        check("rst_acc_overflow", acc_overflow, 0);
        sb.delete();
        reset = 1'b1;
    endtask

    task automatic end_scn(input string name);
        check({name, "_leftover"}, sb.size(), 0);
    endtask

    // One request in WAIT answered manually with the given code, optionally with a bad core-1 exit.
    task automatic wait_verdict(input logic [7:0] code, input logic bad1,
                                input int exp_state, input string name);
        do_reset();
        auto_rsp = 1'b0;
        push(0, 1);
        core_step = 16'h0001;
        tick();
        core_step = '0;
        tick();
        tick();
        m_valid = 1'b1;
        m_code  = code;
        exit_v  = bad1 ? 2'b10 : 2'b00;
        exit_g  = 2'b00;
        tick();
        m_valid = 1'b0;
        exit_v  = '0;
        check({name, "_state"}, sim_state, exp_state);
        check({name, "_perf_hi"}, perf_dump, 1);
        check({name, "_req_valid"}, req_valid, 0);
        tick();
        check({name, "_perf_lo"}, perf_dump, 0);
        repeat (3) tick();
        check({name, "_sticky"}, sim_state, exp_state);
        end_scn(name);
    endtask

    initial begin
        // Single step from core 0.
        do_reset();
        push(0, 3);
        core_step = 16'h0003;
        tick();
        core_step = '0;
        tick();
        check("single_valid", req_valid, 1);
        check("single_nstep", req_nstep, 3);
        repeat (15) tick();
        check("single_run", sim_state, 0);
        check("single_idle", req_valid, 0);
        end_scn("single");

        // Round robin with both cores stepping 1 per cycle for 12 cycles.
        do_reset();
        push(0, 1); push(1, 5); push(0, 8); push(1, 7); push(0, 3);
        core_step = 16'h0101;
        repeat (12) tick();
        core_step = '0;
        repeat (20) tick();
        end_scn("rr");

        // Backpressure: request held while core 0 keeps stepping.
        do_reset();
        req_ready = 1'b0;
        push(0, 2); push(0, 20);
        core_step = 16'h0002;
        tick();
        tick();
        check("bp_valid", req_valid, 1);
        check("bp_nstep", req_nstep, 2);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("bp_hold", req_nstep, 2);
        end
        core_step = '0;
        tick();
        check("bp_hold_last", req_nstep, 2);
        req_ready = 1'b1;
        repeat (15) tick();
        end_scn("bp");

        // Saturation: 255*257 hits the max exactly, the next add overflows.
        do_reset();
        req_ready = 1'b0;
        push(0, 255); push(0, 65535);
        core_step = 16'h00FF;
        repeat (258) tick();
        check("sat_exact_max_no_ovf", acc_overflow, 0);
        tick();
        check("sat_ovf_set", acc_overflow, 1);
        repeat (3) tick();
        core_step = '0;
        req_ready = 1'b1;
        repeat (15) tick();
        check("sat_ovf_sticky", acc_overflow, 1);
        end_scn("sat");

        // Checker verdicts, including simultaneous DONE verdict and bad exit.
        wait_verdict(8'd1, 1'b1, 2, "prio_fail");
        wait_verdict(8'd1, 1'b0, 1, "rsp_done");
        wait_verdict(8'h7F, 1'b0, 2, "rsp_illegal");

        // Good exits from both cores with empty accumulators.
        do_reset();
        exit_v = 2'b01; exit_g = 2'b01;
        tick();
        exit_v = 2'b10; exit_g = 2'b10;
        tick();
        exit_v = '0; exit_g = '0;
        check("exitdone_pending", sim_state, 0);
        tick();
        check("exitdone_state", sim_state, 1);
        check("exitdone_perf", perf_dump, 1);

        // Bad exit while idle in ARB.
        do_reset();
        tick();
        exit_v = 2'b01; exit_g = 2'b00;
        tick();
        exit_v = '0;
        check("badexit_state", sim_state, 2);

        // Watchdog enabled and disabled.
        do_reset();
        stuck_limit = 5;
        repeat (4) tick();
        check("stuck_early", sim_state, 0);
        repeat (2) tick();
        check("stuck_state", sim_state, 3);
        do_reset();
        repeat (60) tick();
        check("stuck_off_run", sim_state, 0);

        // Async reset while a request is pending.
        do_reset();
        req_ready = 1'b0;
        core_step = 16'h0001;
        tick();
        core_step = '0;
        tick();
        check("arst_pre_valid", req_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        check("arst_drop_valid", req_valid, 0);
        check("arst_drop_nstep", req_nstep, 0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
